reduction_frame_ctrl: RTL
=========================

Name: reduction_frame_ctrl

Overview:
Streaming controller that feeds multi-beat frames through a per-beat bitwise reduction stage and accumulates AND/OR/XOR reductions across the whole frame. It also keeps a running population count. Frame-level results (AND, OR, NAND, NOR, XOR, XNOR, ones count, beat count) are presented on a registered valid/ready result port. It sits between a producer of bus words and any consumer needing parity or all-ones/all-zeros status per frame.

Parameters:
DATA_W, 8, width of one input beat
MAX_BEATS, 16, maximum beats accumulated per frame; beats beyond this are dropped
BEAT_W, $clog2(MAX_BEATS+1), width of beat counter
ONES_W, $clog2(MAX_BEATS*DATA_W+1), width of ones counter

Ports:
clk  input  1  clock, all logic rising-edge
rst  input  1  synchronous active-high reset
in_valid  input  1  input beat valid
in_ready  output  1  controller accepts beat
in_data  input  DATA_W  beat payload
in_last  input  1  final beat of frame
out_valid  output  1  frame result valid
out_ready  input  1  consumer accepts result
out_and  output  1  AND of all bits of all accumulated beats
out_or  output  1  OR of all accumulated bits
out_nand  output  1  ~out_and
out_nor  output  1  ~out_or
out_xor  output  1  XOR of all accumulated bits
out_nxor  output  1  ~out_xor
out_ones  output  ONES_W  count of 1 bits over accumulated beats
out_beats  output  BEAT_W  number of beats accumulated (1..MAX_BEATS)
out_trunc  output  1  frame exceeded MAX_BEATS; extra beats dropped

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst). Both are fixed.
- Reset values: state IDLE, in_ready=0 during the reset cycle, out_valid=0. All result registers are 0, except out_nand=1, out_nor=1 and out_nxor=1 (complements of 0).
- A beat is accepted when in_valid & in_ready on a rising edge. A result is consumed when out_valid & out_ready.
- FSM states: IDLE, ACCUM, DRAIN, HOLD.
- IDLE: in_ready=1. On an accepted beat, initialise accumulators:
  - and_acc=&in_data, or_acc=|in_data, xor_acc=^in_data
  - ones=popcount(in_data), beats=1, trunc=0
  - Next state: HOLD if in_last, else ACCUM. (If MAX_BEATS=1 and not in_last: set trunc, go to DRAIN.)
- ACCUM: in_ready=1. On an accepted beat:
  - and_acc&=&in_data, or_acc|=|in_data, xor_acc^=^in_data
  - ones+=popcount(in_data), beats+=1
  - If in_last: go to HOLD.
  - Else if beats+1==MAX_BEATS: set trunc, go to DRAIN.
- DRAIN: in_ready=1. Accepted beats are discarded; accumulators are unchanged. When in_last is accepted, go to HOLD.
- HOLD: in_ready=0, out_valid=1. Result registers are stable. On out_ready, go to IDLE and clear out_valid.
  - No same-cycle bypass: a new frame can be accepted at the earliest in the cycle after consumption.
- Latency: out_valid rises on the clock edge that accepts the last beat, i.e. it is visible in the cycle after the last handshake.
- Arithmetic: ones is unsigned and cannot overflow given ONES_W. out_xor always equals out_ones[0].
- in_data and in_last are ignored when in_valid=0. in_valid low mid-frame stalls with no state change.
- rst asserted mid-frame or in HOLD aborts the frame: the partial result is discarded, out_valid=0 next cycle, and the FSM is in IDLE.

Decomposition:
- Package reduction_pkg holds:
  - state enum (IDLE, ACCUM, DRAIN, HOLD)
  - default DATA_W and MAX_BEATS
  - a popcount function parameterised on DATA_W
- One sub-module, reduction_beat: purely combinational, DATA_W-wide. Outputs per-beat and/or/xor and popcount.
- The controller instantiates one reduction_beat and holds the FSM, accumulators, counters and handshake logic.

Test Plan:
1. Single-beat frame 8'hFF, in_last=1, out_ready=1 -> next cycle out_valid=1, and=1, or=1, nand=0, nor=0, xor=0, nxor=1, ones=8, beats=1, trunc=0.
2. Frame 8'h01, 8'h02, 8'h00 (last) -> and=0, or=1, xor=0, ones=2, beats=3. Frame 8'h00, 8'h00 (last) -> or=0, nor=1, ones=0.
3. Backpressure: out_ready=0 for 5 cycles after result -> out_valid and all results held, in_ready=0 throughout. Release -> out_valid drops, in_ready=1 next cycle.
4. Overflow, MAX_BEATS=16: 20 beats of 8'h80, last on beat 20 -> beats=16, ones=16, xor=0, trunc=1. Beats 17-20 are accepted (in_ready=1) but not counted.
5. in_valid gaps: 3-beat frame 8'h07, 8'h01, 8'h01 with 2 idle cycles between beats -> ones=5, xor=1, beats=3; same result as without gaps.
6. rst pulsed after 2 of 4 beats -> out_valid stays 0. Then new frame 8'hAA (last) -> ones=4, beats=1, trunc=0; no residue from the aborted frame.

Source files
------------

// File: rtl/reduction_pkg.sv
// Shared definitions for the frame reduction controller: FSM state encoding,
// default geometry and a bit-count helper used by the per-beat reducer.
package reduction_pkg;

  localparam int unsigned DATA_W_DEF    = 8;
  localparam int unsigned MAX_BEATS_DEF = 16;

  // Widest beat the popcount helper supports; callers zero-extend into it.
  localparam int unsigned POP_MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // Counts set bits in the low `width` bits of v (width <= POP_MAX_W).
  function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v,
                                           input int unsigned width);
    int unsigned cnt;
    cnt = 0;
    for (int unsigned i = 0; i < POP_MAX_W; i++) begin
      if (i < width && v[i]) cnt = cnt + 1;
    end
    return cnt;
  endfunction

endpackage

// File: rtl/reduction_beat.sv
// Combinational per-beat reducer: AND/OR/XOR of all bits plus ones count.
// Ports: data (DATA_W) in; and_c, or_c, xor_c, ones_c out (all combinational).
module reduction_beat
  import reduction_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  localparam int unsigned PC_W  = $clog2(DATA_W + 1)
) (
  input  logic [DATA_W-1:0] data,
  output logic              and_c,
  output logic              or_c,
  output logic              xor_c,
  output logic [PC_W-1:0]   ones_c
);

  always_comb begin
    and_c  = &data;
    or_c   = |data;
    xor_c  = ^data;
    ones_c = PC_W'(popcount(POP_MAX_W'(data), DATA_W));
  end

endmodule

// File: rtl/reduction_frame_ctrl.sv
// Frame reduction controller: accepts multi-beat frames on a valid/ready input,
// accumulates AND/OR/XOR and ones/beat counts across up to MAX_BEATS beats, and
// presents the registered frame result on a valid/ready output.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_data/in_last;
//        out_valid/out_ready; out_and/or/nand/nor/xor/nxor, out_ones,
//        out_beats, out_trunc.
module reduction_frame_ctrl
  import reduction_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned MAX_BEATS = MAX_BEATS_DEF,
  localparam int unsigned BEAT_W   = $clog2(MAX_BEATS + 1),
  localparam int unsigned ONES_W   = $clog2(MAX_BEATS * DATA_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_and,
  output logic              out_or,
  output logic              out_nand,
  output logic              out_nor,
  output logic              out_xor,
  output logic              out_nxor,
  output logic [ONES_W-1:0] out_ones,
  output logic [BEAT_W-1:0] out_beats,
  output logic              out_trunc
);

  localparam int unsigned PC_W = $clog2(DATA_W + 1);

  state_t            state_q, state_d;
  logic              accept;
  logic              b_and, b_or, b_xor;
  logic [PC_W-1:0]   b_ones;
  logic              and_d, or_d, xor_d, trunc_d;
  logic [ONES_W-1:0] ones_d;
  logic [BEAT_W-1:0] beats_d;

  reduction_beat #(.DATA_W(DATA_W)) u_beat (
    .data   (in_data),
    .and_c  (b_and),
    .or_c   (b_or),
    .xor_c  (b_xor),
    .ones_c (b_ones)
  );

  // Next-state and next-accumulator logic.
  always_comb begin
    state_d = state_q;
    and_d   = out_and;
    or_d    = out_or;
    xor_d   = out_xor;
    ones_d  = out_ones;
    beats_d = out_beats;
    trunc_d = out_trunc;
    accept  = in_valid & in_ready;

    case (state_q)
      IDLE: begin
        if (accept) begin
          and_d   = b_and;
          or_d    = b_or;
          xor_d   = b_xor;
          ones_d  = ONES_W'(b_ones);
          beats_d = BEAT_W'(1);
          trunc_d = 1'b0;
          if (in_last) begin
            state_d = HOLD;
          end else if (MAX_BEATS == 1) begin
            trunc_d = 1'b1;
            state_d = DRAIN;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (accept) begin
          and_d   = out_and & b_and;
          or_d    = out_or | b_or;
          xor_d   = out_xor ^ b_xor;
          ones_d  = out_ones + ONES_W'(b_ones);
          beats_d = out_beats + BEAT_W'(1);
          if (in_last) begin
            state_d = HOLD;
          end else if (out_beats + BEAT_W'(1) == BEAT_W'(MAX_BEATS)) begin
            // Frame is full; swallow the rest of it up to in_last.
            trunc_d = 1'b1;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (accept && in_last) state_d = HOLD;
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; handshake flags follow the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_and   <= 1'b0;
      out_or    <= 1'b0;
      out_xor   <= 1'b0;
      out_nand  <= 1'b1;
      out_nor   <= 1'b1;
      out_nxor  <= 1'b1;
      out_ones  <= '0;
      out_beats <= '0;
      out_trunc <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_ready  <= (state_d != HOLD);
      out_valid <= (state_d == HOLD);
      out_and   <= and_d;
      out_or    <= or_d;
      out_xor   <= xor_d;
      out_nand  <= ~and_d;
      out_nor   <= ~or_d;
      out_nxor  <= ~xor_d;
      out_ones  <= ones_d;
      out_beats <= beats_d;
      out_trunc <= trunc_d;
    end
  end

endmodule
